// File: rtl/signature_checker.sv
// Signature checker: runs a 255-step stimulus counter, folds scrambled
// observation words into a 16-bit rotating accumulator, and compares the result to a golden value.
module signature_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  seed,
  input  logic [15:0] expected,
  input  logic [7:0]  obs,
  output logic [7:0]  stimulus,
  output logic [3:0]  i_pins,
  output logic [15:0] signature,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  seed_q, seed_d;
  logic [15:0] expected_q, expected_d;
  logic [7:0]  stimulus_q, stimulus_d;
  logic [15:0] signature_q, signature_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  scr;
  logic [7:0]  add;

  assign scr = seed_q ^ obs;
  assign add = signature_q[7:0] + scr;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    expected_d  = expected_q;
    stimulus_d  = stimulus_q;
    signature_d = signature_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d      = seed;
          expected_d  = expected;
          stimulus_d  = 8'h00;
          signature_d = 16'h0000;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Start requests are deliberately ignored while running.
        if (stimulus_q != 8'hFF) begin
          signature_d = {signature_q[14:8], add, signature_q[15]};
          stimulus_d  = stimulus_q + 8'd1;
        end else begin
          pass_d  = (signature_q == expected_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      seed_q      <= 8'h00;
      expected_q  <= 16'h0000;
      stimulus_q  <= 8'h00;
      signature_q <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      expected_q  <= expected_d;
      stimulus_q  <= stimulus_d;
      signature_q <= signature_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign stimulus  = stimulus_q;
  assign i_pins    = stimulus_q[7:4];
  assign signature = signature_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_signature_checker.sv
// Directed bench for signature_checker: a table of full runs with
// hand-computed signatures, plus restart, ignored-start and mid-run reset sequences.
module tb_signature_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  seed;
  logic [15:0] expected;
  logic [7:0]  obs;
  logic [7:0]  stimulus;
  logic [3:0]  i_pins;
  logic [15:0] signature;
  logic        busy, done, pass;

  int checks = 0;
  int failures = 0;

  signature_checker dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .expected(expected),
    .obs(obs), .stimulus(stimulus), .i_pins(i_pins), .signature(signature),
    .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  // obs0 applies on the first accumulate edge, obs1 on the second, obs_rest after.
  typedef struct {
    logic [7:0]  seed;
    logic [7:0]  obs0;
    logic [7:0]  obs1;
    logic [7:0]  obs_rest;
    logic [15:0] expected;
    logic [15:0] sig1;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic run_one(input vec_t v, input int pulse_at, input string tag);
    logic [7:0] nb;
    seed = v.seed; expected = v.expected; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Changing the inputs after acceptance must not disturb the run.
    seed = ~v.seed; expected = ~v.expected;
    chk({tag, " start busy"}, 32'(busy), 32'd1);
    chk({tag, " start stim"}, 32'(stimulus), 32'd0);
    chk({tag, " start sig"}, 32'(signature), 32'd0);
    chk({tag, " start done"}, 32'(done), 32'd0);
    chk({tag, " start pass"}, 32'(pass), 32'd0);
    for (int n = 1; n <= 255; n++) begin
      obs   = (n == 1) ? v.obs0 : (n == 2) ? v.obs1 : v.obs_rest;
      start = ((n - 1) == pulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      nb = n[7:0];
      chk({tag, " stim"}, 32'(stimulus), 32'(nb));
      chk({tag, " i_pins"}, 32'(i_pins), 32'(nb[7:4]));
      chk({tag, " done early"}, 32'(done), 32'd0);
      if (n == 1) chk({tag, " sig1"}, 32'(signature), 32'(v.sig1));
    end
    obs = 8'hA5;
    @(posedge clk); #1;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
    chk({tag, " sig"}, 32'(signature), 32'(v.exp_sig));
    chk({tag, " stim end"}, 32'(stimulus), 32'hFF);
    for (int h = 0; h < 3; h++) begin
      obs = 8'(h * 37 + 11);
      @(posedge clk); #1;
      chk({tag, " hold done"}, 32'(done), 32'd1);
      chk({tag, " hold sig"}, 32'(signature), 32'(v.exp_sig));
      chk({tag, " hold pass"}, 32'(pass), 32'(v.exp_pass));
      chk({tag, " hold stim"}, 32'(stimulus), 32'hFF);
    end
  endtask

  initial begin
    //            seed   obs0   obs1   rest   expected  sig1      final     pass
    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'h00, 8'h00, 16'h8000, 16'h0002, 16'h8000, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{8'h00, 8'h02, 8'h00, 8'h00, 16'h0001, 16'h0004, 16'h0001, 1'b1};
    // Carry out of the 8-bit add is dropped: FE + 02 -> 00.
    vecs[5] = '{8'h00, 8'hFF, 8'h02, 8'h00, 16'h0040, 16'h01FE, 16'h0040, 1'b1};
    vecs[6] = '{8'h01, 8'h00, 8'h01, 8'h01, 16'h7FFF, 16'h0002, 16'h8000, 1'b0};

    reset = 1'b0; start = 1'b1; seed = 8'h5A; expected = 16'h1234; obs = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stim", 32'(stimulus), 32'd0);
    chk("reset sig", 32'(signature), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset pass", 32'(pass), 32'd0);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle wait busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_one(vecs[i], -1, $sformatf("vec%0d", i));

    // Start pulse mid-run is ignored; then restart straight from DONE.
    run_one(vecs[2], 16, "pulse run");
    run_one(vecs[2], -1, "restart run");

    // Abort mid-run; reset wins over a simultaneous start.
    seed = 8'h00; expected = 16'h0000; start = 1'b1; obs = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8'h40) @(posedge clk);
    #1;
    chk("pre-abort stim", 32'(stimulus), 32'h40);
    reset = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    chk("abort stim", 32'(stimulus), 32'd0);
    chk("abort sig", 32'(signature), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort i_pins", 32'(i_pins), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post-abort idle busy", 32'(busy), 32'd0);
    chk("post-abort idle stim", 32'(stimulus), 32'd0);
    chk("post-abort idle done", 32'(done), 32'd0);
    run_one(vecs[0], -1, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signature_checker.md
SIGNATURE_CHECKER -- requirements
Module: signature_checker

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 start  input  1  run request, sampled high for one or more cycles.
REQ-004 seed  input  8  scramble seed, latched on accepted start.
REQ-005 expected  input  16  golden signature, latched on accepted start.
REQ-006 obs  input  8  observation word, pre-XORed externally from the microprocessor debug buses.
REQ-007 stimulus  output  8  run counter.
REQ-008 i_pins  output  4  stimulus[7:4]; drives the microprocessor i_pins.
REQ-009 signature  output  16  accumulator value.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  compare result; valid only while done=1, else 0.

Function
REQ-013 The checker SHALL implement states IDLE, RUN, DONE (2-bit encoding, registered).
REQ-014 IDLE: start=1 SHALL latch seed/expected, clear stimulus and signature to 0, and enter RUN at that edge.
REQ-015 RUN, stimulus != 8'hFF: the checker SHALL compute scr = seed_q ^ obs.
REQ-016 In the same case it SHALL compute add = signature[7:0] + scr, modulo 256 with carry discarded.
REQ-017 In the same case it SHALL load signature <= {signature[14:8], add, signature[15]}.
REQ-018 In the same case it SHALL increment stimulus by 1.
REQ-019 RUN, stimulus == 8'hFF (counter full): signature and stimulus SHALL hold, pass SHALL register (signature == expected_q), and the state SHALL go to DONE.
REQ-020 Exactly 255 accumulate edges SHALL occur per run, for stimulus 00..FE.
REQ-021 Latency: start accepted at edge k; done=1 and pass valid after edge k+256.
REQ-022 DONE SHALL hold signature, stimulus, and pass stable until start or reset.
REQ-023 DONE with start=1 SHALL restart exactly as in REQ-014.
REQ-024 start in RUN SHALL be ignored, with no restart and no re-latch of seed or expected.
REQ-025 seed/expected changes after acceptance SHALL NOT affect the current run.
REQ-026 obs SHALL be sampled only on accumulate edges; obs on the hold edge is ignored.
REQ-027 busy, done, and pass SHALL be registered outputs, and i_pins SHALL be combinational from stimulus.

Reset
REQ-028 reset=0 at any rising edge SHALL force IDLE, stimulus=8'h00, signature=16'h0000, busy=0, done=0, pass=0, seed_q=0, expected_q=0.
REQ-029 Reset SHALL override start on the same edge.
REQ-030 Reset mid-RUN SHALL abort the run with no partial done or pass.
REQ-031 After reset release, the checker SHALL wait in IDLE for start.

Verification
REQ-032 seed=00, obs=00 constant, expected=0000, start -> done at edge k+256, signature=0000, pass=1.
REQ-033 As REQ-032 but expected=0001 -> signature=0000, done=1, pass=0.
REQ-034 seed=00, obs=01 only while stimulus==00, else 00, expected=8000 -> signature=0002 after first accumulate edge, final 8000, pass=1.
REQ-035 seed=FF, obs=FF constant -> scr=00 each cycle, signature=0000; i_pins steps 0..F with stimulus.
REQ-036 reset=0 one cycle while stimulus=40 -> all outputs 0 and IDLE; rerun with REQ-032 stimulus -> identical result.
REQ-037 start pulsed at stimulus=10 during RUN, then restart from DONE -> first run unaffected (done at k+256); second run gives the same signature with stimulus restarted at 00.
